// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states
// and move-to register selects.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    localparam logic MT_LO = 1'b0;
    localparam logic MT_HI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the unsigned magnitude datapath: a shift-add multiply step
// or a restoring-divide step on a {hi, lo} accumulator.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]       div_shl;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_acc;

    // Multiply: low half holds the unconsumed multiplier bits, product grows in from the top.
    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        mul_acc = {mul_sum, acc_i[WIDTH-1:1]};
    end

    // Divide: the partial remainder needs one extra bit after the shift, so the
    // compare uses the full WIDTH+1 value and the subtract only the low WIDTH bits.
    always_comb begin
        div_shl  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        div_ge   = (div_shl >= {1'b0, opnd_i});
        div_diff = div_shl[WIDTH-1:0] - opnd_i;
        div_rem  = div_ge ? div_diff : div_shl[WIDTH-1:0];
        div_acc  = {div_rem, acc_i[WIDTH-2:0], div_ge};
    end

    assign acc_o = is_div ? div_acc : mul_acc;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and
// MTHI/MTLO support; works on magnitudes and fixes signs at the end.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             MtEn,
    input  logic             MtSel,
    input  logic [WIDTH-1:0] MtData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [2:0]       DbgState
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               res_neg_q, rem_neg_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   mag_a_d, mag_b_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quot_d, rem_d;
    logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    always_comb begin
        mag_a_d = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b_d = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div (is_div),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_d)
    );

    // Divide by zero bypasses the sign fix: HI gets the raw dividend, LO all ones.
    always_comb begin
        prod_d   = res_neg_q ? -acc_q : acc_q;
        quot_d   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d    = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
        fix_lo_d = prod_d[WIDTH-1:0];
        if (is_div) begin
            if (opnd_q == '0) begin
                fix_hi_d = a_q;
                fix_lo_d = '1;
            end else begin
                fix_hi_d = rem_d;
                fix_lo_d = quot_d;
            end
        end
    end

    // Handshake: Start is accepted only in IDLE (it wins over MtEn there);
    // Busy is high from the cycle after acceptance until results land, and
    // Done is a single-cycle pulse in the cycle Hi/Lo first show the result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        op_q    <= Op;
                        a_q     <= OperandA;
                        b_q     <= OperandB;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end else if (MtEn) begin
                        if (MtSel == MT_HI) hi_q <= MtData;
                        else                lo_q <= MtData;
                    end
                end
                ST_PREP: begin
                    opnd_q    <= mag_b_d;
                    acc_q     <= {{WIDTH{1'b0}}, mag_a_d};
                    cnt_q     <= '0;
                    res_neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rem_neg_q <= is_signed & a_q[WIDTH-1];
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: arithmetic vectors, latency, handshake
// corner cases, move-to behaviour and mid-operation reset.
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic [31:0] OperandA = '0, OperandB = '0;
    logic        MtEn = 1'b0, MtSel = 1'b0;
    logic [31:0] MtData = '0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;
    logic [2:0]  DbgState;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .MtEn(MtEn), .MtSel(MtSel), .MtData(MtData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DbgState(DbgState)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge) and follow it to completion.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit mt_at_start,
                          input bit poke_run, input bit poke_done);
        int n, busy_n;
        bit hold_ok;
        logic [31:0] hi0, lo0, e_hi, e_lo;
        exp_q.push_back(exp_hi);
        exp_q.push_back(exp_lo);
        hi0 = Hi;
        lo0 = Lo;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        if (mt_at_start) begin
            MtEn = 1'b1; MtSel = MT_LO; MtData = 32'h0000DEAD;
        end
        @(negedge Clk);
        Start = 1'b0; MtEn = 1'b0;
        OperandA = $urandom; OperandB = $urandom;
        n = 1; busy_n = 0; hold_ok = 1'b1;
        while (!Done && n < 100) begin
            if (Busy) busy_n++;
            if (Hi !== hi0 || Lo !== lo0) hold_ok = 1'b0;
            if (poke_run && busy_n == 5) begin
                Start = 1'b1; Op = OP_DIV; OperandA = 32'd1; OperandB = 32'd1;
                MtEn = 1'b1; MtSel = MT_HI; MtData = 32'hBAD0BAD0;
            end else begin
                Start = 1'b0; MtEn = 1'b0;
            end
            @(negedge Clk);
            n++;
        end
        Start = 1'b0; MtEn = 1'b0;
        e_hi = exp_q.pop_front();
        e_lo = exp_q.pop_front();
        check({tag, "_latency"}, 32'(n - 1), 32'd34);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd34);
        check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, "_hi"}, Hi, e_hi);
        check({tag, "_lo"}, Lo, e_lo);
        if (poke_done) begin
            Start = 1'b1; Op = OP_MULTU; OperandA = 32'd9; OperandB = 32'd9;
            MtEn = 1'b1; MtSel = MT_LO; MtData = 32'h0BADF00D;
        end
        @(negedge Clk);
        Start = 1'b0; MtEn = 1'b0;
        check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
        if (poke_done) check({tag, "_done_mt_dropped"}, Lo, e_lo);
    endtask

    initial begin
        int done_n, busy_n;

        // Reset block
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        check("rst_state", {29'd0, DbgState}, 32'd0);

        run_op("mult_neg1x3",  OP_MULT,  32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
        run_op("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0, 0);
        run_op("mult_minmin",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 0);
        run_op("div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
        run_op("divu_7_2",     OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0, 0, 0);
        run_op("div_7_m2",     OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0, 0);
        run_op("div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 0);
        run_op("divu_5_0",     OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0, 0, 0);
        run_op("div_m5_0",     OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 0, 0);
        run_op("divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       0, 1, 1);

        // No ghost operation from the ignored Start pulses
        busy_n = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Busy || Done) busy_n++;
        end
        check("no_ghost_op", 32'(busy_n), 32'd0);
        check("no_ghost_hi", Hi, 32'd2);

        // Reset in the 10th RUN cycle
        Start = 1'b1; Op = OP_MULT; OperandA = 32'h00001234; OperandB = 32'h00005678;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        check("pre_rst_state", {29'd0, DbgState}, 32'd2);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_hi", Hi, 32'd0);
        check("midrst_lo", Lo, 32'd0);
        done_n = 0; busy_n = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) done_n++;
            if (Busy) busy_n++;
        end
        check("midrst_no_done", 32'(done_n), 32'd0);
        check("midrst_no_busy", 32'(busy_n), 32'd0);

        run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0, 0);

        // Move-to in IDLE
        MtEn = 1'b1; MtSel = MT_HI; MtData = 32'h12345678;
        @(negedge Clk);
        MtEn = 1'b0;
        check("mthi_hi", Hi, 32'h12345678);
        check("mthi_lo", Lo, 32'd42);
        MtEn = 1'b1; MtSel = MT_LO; MtData = 32'hCAFEBABE;
        @(negedge Clk);
        MtEn = 1'b0;
        check("mtlo_lo", Lo, 32'hCAFEBABE);
        check("mtlo_hi", Hi, 32'h12345678);

        // Start and MtEn together: the operation wins
        run_op("start_mt", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
